// File: rtl/aes128_wb_regs.sv
// Wishbone register front-end for the aes128 core: key/state load, run sequencing, ciphertext capture.
// Optional completion interrupt is built only when AES128_WB_IRQ_EN is defined.
module aes128_wb_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          AES_LATENCY = 21
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] aes_key_o,
    output logic [127:0] aes_state_o,
    input  logic [127:0] aes_out_i,
    output logic         irq_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE_S} fsm_t;

    localparam logic [7:0] LAT = 8'(AES_LATENCY);

    fsm_t        fsm;
    logic [7:0]  cnt;
    logic        done;
    logic        irq_bit;
    logic [31:0] key_r   [4];
    logic [31:0] state_r [4];
    logic [31:0] out_r   [4];
    logic [31:0] rdata;

    // Handshake: cyc&stb with an in-window address while ack is low is one access.
    // It commits at that edge; ack is high for exactly the next cycle, then forced
    // low, so a held stb is served every other cycle. Out-of-window is never acked.
    logic       hit, access, wr, busy;
    logic [5:0] word;
    logic       ctrl_wr, start_wr, irq_clr, capture;

    assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign access   = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
    assign wr       = access && wbs_we_i;
    assign word     = wbs_adr_i[7:2];
    assign busy     = (fsm == BUSY);
    // CTRL bits live in byte lane 0.
    assign ctrl_wr  = wr && (word == 6'h0c) && wbs_sel_i[0];
    assign start_wr = ctrl_wr && wbs_dat_i[0];
    assign irq_clr  = ctrl_wr && wbs_dat_i[1];
    assign capture  = busy && (cnt == 8'd1);

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    always_comb begin
        rdata = '0;
        case (wbs_adr_i[7:4])
            4'h0: rdata = key_r[wbs_adr_i[3:2]];
            4'h1: rdata = state_r[wbs_adr_i[3:2]];
            4'h2: rdata = out_r[wbs_adr_i[3:2]];
            4'h3: if (wbs_adr_i[3:2] == 2'd1) rdata = {29'd0, irq_bit, done, busy};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            if (access) wbs_dat_o <= rdata;
        end
    end

    // Core inputs are frozen for the whole run.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 4; i++) begin
                key_r[i]   <= '0;
                state_r[i] <= '0;
            end
        end else if (wr && !busy) begin
            if (wbs_adr_i[7:4] == 4'h0)
                key_r[wbs_adr_i[3:2]] <= merge(key_r[wbs_adr_i[3:2]], wbs_dat_i, wbs_sel_i);
            if (wbs_adr_i[7:4] == 4'h1)
                state_r[wbs_adr_i[3:2]] <= merge(state_r[wbs_adr_i[3:2]], wbs_dat_i, wbs_sel_i);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            fsm  <= IDLE;
            cnt  <= '0;
            done <= 1'b0;
            for (int i = 0; i < 4; i++) out_r[i] <= '0;
        end else begin
            case (fsm)
                IDLE, DONE_S: begin
                    if (start_wr) begin
                        fsm  <= BUSY;
                        cnt  <= LAT;
                        done <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (capture) begin
                        out_r[0] <= aes_out_i[127:96];
                        out_r[1] <= aes_out_i[95:64];
                        out_r[2] <= aes_out_i[63:32];
                        out_r[3] <= aes_out_i[31:0];
                        done     <= 1'b1;
                        fsm      <= DONE_S;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef AES128_WB_IRQ_EN
    logic irq_r;
    // A completion in the same cycle as IRQ_CLR keeps the interrupt pending.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)     irq_r <= 1'b0;
        else if (capture) irq_r <= 1'b1;
        else if (irq_clr) irq_r <= 1'b0;
    end
    assign irq_bit = irq_r;
    assign irq_o   = irq_r;
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0]};
`else
    assign irq_bit = 1'b0;
    assign irq_o   = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0], irq_clr};
`endif

    assign aes_key_o   = {key_r[0], key_r[1], key_r[2], key_r[3]};
    assign aes_state_o = {state_r[0], state_r[1], state_r[2], state_r[3]};

endmodule

// File: tb/tb_aes128_wb_regs.sv
// Directed bench for aes128_wb_regs; the bench itself plays the aes128 core by driving aes_out_i.
// Expectations follow AES128_WB_IRQ_EN when it is defined for the build.
module tb_aes128_wb_regs;

    localparam int          L      = 21;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] CTRL   = BASE + 32'h30;
    localparam logic [31:0] STATUS = BASE + 32'h34;
`ifdef AES128_WB_IRQ_EN
    localparam logic [31:0] IRQ_BIT = 32'd4;
    localparam logic        IRQ_ON  = 1'b1;
`else
    localparam logic [31:0] IRQ_BIT = 32'd0;
    localparam logic        IRQ_ON  = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'h0;
    logic [31:0]  adr = '0, wdat = '0;
    logic         ack;
    logic [31:0]  rdat;
    logic [127:0] key_o, state_o;
    logic [127:0] aes_out = '0;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    aes128_wb_regs #(.BASE_ADDR(BASE), .AES_LATENCY(L)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .aes_key_o(key_o), .aes_state_o(state_o),
        .aes_out_i(aes_out), .irq_o(irq)
    );

    // Clock and free-running cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic acked);
        int n = 0;
        @(negedge clk);
        while (ack && n < 4) begin
            @(negedge clk);
            n++;
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        rd = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acked = 1'b1;
                rd = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic acked;
        wb_xfer(1'b1, a, d, s, rd, acked);
        check($sformatf("ack_wr_%0h", a), {127'd0, acked}, 128'd1);
    endtask

    task automatic wb_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic acked;
        wb_xfer(1'b0, a, 32'd0, 4'hf, rd, acked);
        check({tag, "_ack"}, {127'd0, acked}, 128'd1);
        check(tag, {96'd0, rd}, {96'd0, exp});
    endtask

    logic [127:0] key_v  = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] st_v   = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] ct_v   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] ct2_v  = 128'h0123456789abcdeffedcba9876543210;
    logic [127:0] junk_v = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    initial begin
        int e0;
        logic [31:0] rd;
        logic acked;

        // Reset: two cycles, then every output and every map offset reads 0
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("rst_ack", {127'd0, ack}, 128'd0);
        check("rst_dat", {96'd0, rdat}, 128'd0);
        check("rst_irq", {127'd0, irq}, 128'd0);
        check("rst_key", key_o, 128'd0);
        check("rst_state", state_o, 128'd0);
        for (int i = 0; i < 15; i++)
            wb_read_check($sformatf("rst_rd_%0h", 4 * i), BASE + 32'(4 * i), 32'd0);

        // Byte enables over a zero register
        wb_write(BASE, 32'haabbccdd, 4'b0101);
        wb_read_check("byte_en", BASE, 32'h00bb00dd);

        // Load FIPS-197 key and plaintext
        for (int i = 0; i < 4; i++) begin
            wb_write(BASE + 32'(4 * i), key_v[127 - 32 * i -: 32], 4'hf);
            wb_write(BASE + 32'h10 + 32'(4 * i), st_v[127 - 32 * i -: 32], 4'hf);
        end
        check("key_o", key_o, key_v);
        check("state_o", state_o, st_v);
        wb_read_check("key1_rd", BASE + 32'h4, 32'h04050607);

        // Run 1: the core output is correct only around edge E0+L
        wb_write(CTRL, 32'h1, 4'hf);
        aes_out = junk_v;
        repeat (L - 1) @(posedge clk);
        #1 aes_out = ct_v;
        @(posedge clk);
        #1 aes_out = ~junk_v;
        for (int i = 0; i < 4; i++)
            wb_read_check($sformatf("run1_out%0d", i), BASE + 32'h20 + 32'(4 * i),
                          ct_v[127 - 32 * i -: 32]);
        wb_read_check("run1_status", STATUS, 32'h2 | IRQ_BIT);
        check("run1_irq", {127'd0, irq}, {127'd0, IRQ_ON});
        wb_read_check("ctrl_rd", CTRL, 32'd0);

        // Run 2: busy lockout, previous result visible, ignored re-START
        wb_write(CTRL, 32'h1, 4'hf);
        e0 = cyc_cnt;
        fork
            begin
                repeat (L - 1) @(posedge clk);
                #1 aes_out = ct2_v;
                @(posedge clk);
                #1 aes_out = junk_v;
            end
        join_none
        wb_read_check("run2_busy", STATUS, 32'h1 | IRQ_BIT);
        wb_read_check("run2_old_out0", BASE + 32'h20, 32'h69c4e0d8);
        wb_write(BASE + 32'h14, 32'hffffffff, 4'hf);
        check("run2_state_frozen", state_o, st_v);
        wb_write(CTRL, 32'h1, 4'hf);
        wb_write(BASE, 32'h0, 4'hf);
        check("run2_key_frozen", key_o, key_v);
        while (cyc_cnt < e0 + L + 1) @(posedge clk);
        for (int i = 0; i < 4; i++)
            wb_read_check($sformatf("run2_out%0d", i), BASE + 32'h20 + 32'(4 * i),
                          ct2_v[127 - 32 * i -: 32]);
        wb_read_check("run2_status", STATUS, 32'h2 | IRQ_BIT);

        // IRQ clear keeps DONE; START+IRQ_CLR launches with IRQ low
        wb_write(CTRL, 32'h2, 4'hf);
        check("irqclr_irq", {127'd0, irq}, 128'd0);
        wb_read_check("irqclr_status", STATUS, 32'h2);
        wb_write(CTRL, 32'h3, 4'hf);
        e0 = cyc_cnt;
        check("run3_irq", {127'd0, irq}, 128'd0);
        wb_read_check("run3_busy", STATUS, 32'h1);

        // Reset on cycle 10 of the run: everything cleared, no later capture
        aes_out = junk_v;
        while (cyc_cnt < e0 + 10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("midrst_ack", {127'd0, ack}, 128'd0);
        check("midrst_dat", {96'd0, rdat}, 128'd0);
        check("midrst_irq", {127'd0, irq}, 128'd0);
        check("midrst_key", key_o, 128'd0);
        check("midrst_state", state_o, 128'd0);
        repeat (L + 10) @(posedge clk);
        wb_read_check("midrst_out0", BASE + 32'h20, 32'd0);
        wb_read_check("midrst_out3", BASE + 32'h2c, 32'd0);
        wb_read_check("midrst_status", STATUS, 32'd0);

        // Decode: outside the window never acks and never writes
        wb_xfer(1'b1, BASE + 32'h100, 32'h12345678, 4'hf, rd, acked);
        check("oow_wr_ack", {127'd0, acked}, 128'd0);
        check("oow_key", key_o, 128'd0);
        wb_xfer(1'b0, BASE + 32'h100, 32'd0, 4'hf, rd, acked);
        check("oow_rd_ack", {127'd0, acked}, 128'd0);
        wb_xfer(1'b1, BASE + 32'h130, 32'h1, 4'hf, rd, acked);
        wb_read_check("oow_no_start", STATUS, 32'd0);

        // Unmapped in-window offset: acked, reads 0, write ignored
        wb_write(BASE + 32'h38, 32'hffffffff, 4'hf);
        wb_read_check("unmapped_rd", BASE + 32'h38, 32'd0);
        check("unmapped_key", key_o, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
